// File: rtl/seven_seg_capture.sv
// Receive side of a two-digit multiplexed seven-segment bus: waits for each
// phase to settle, captures both digits, and commits a decoded frame.
module seven_seg_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned TBITS   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        digit_sel,
  output logic [13:0] both7seg_out,
  output logic [3:0]  hex_hi,
  output logic [3:0]  hex_lo,
  output logic [1:0]  blank,
  output logic [1:0]  code_err,
  output logic        frame_valid,
  output logic        scan_lost
);

  localparam logic [0:0] ST_SETTLING = 1'b0;
  localparam logic [0:0] ST_CAPTURED = 1'b1;

  localparam logic [3:0]       SETTLE_C  = 4'(SETTLE);
  localparam logic [TBITS-1:0] TIMEOUT_C = TBITS'(TIMEOUT);

  logic [7:0]       s_q, s_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [6:0]       pend_hi_q, pend_hi_d;
  logic [6:0]       pend_lo_q, pend_lo_d;
  logic             got_hi_q, got_hi_d;
  logic             got_lo_q, got_lo_d;
  logic [TBITS-1:0] wd_q, wd_d;
  logic             scan_lost_q, scan_lost_d;
  logic [13:0]      word_q, word_d;
  logic [3:0]       hex_hi_q, hex_hi_d;
  logic [3:0]       hex_lo_q, hex_lo_d;
  logic [1:0]       blank_q, blank_d;
  logic [1:0]       code_err_q, code_err_d;
  logic             frame_valid_q, frame_valid_d;
  logic             capture;
  logic             commit;
  logic [5:0]       dec_hi, dec_lo;

  // Result packed as {code_err, blank, hex[3:0]}.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = {2'b00, 4'h0};
      7'h06:   decode = {2'b00, 4'h1};
      7'h5B:   decode = {2'b00, 4'h2};
      7'h4F:   decode = {2'b00, 4'h3};
      7'h66:   decode = {2'b00, 4'h4};
      7'h6D:   decode = {2'b00, 4'h5};
      7'h7D:   decode = {2'b00, 4'h6};
      7'h07:   decode = {2'b00, 4'h7};
      7'h7F:   decode = {2'b00, 4'h8};
      7'h6F:   decode = {2'b00, 4'h9};
      7'h77:   decode = {2'b00, 4'hA};
      7'h7C:   decode = {2'b00, 4'hB};
      7'h39:   decode = {2'b00, 4'hC};
      7'h5E:   decode = {2'b00, 4'hD};
      7'h79:   decode = {2'b00, 4'hE};
      7'h71:   decode = {2'b00, 4'hF};
      7'h00:   decode = {2'b01, 4'h0};
      default: decode = {2'b10, 4'h0};
    endcase
  endfunction

  always_comb begin
    s_d        = {digit_sel, segment};
    cnt_d      = cnt_q;
    state_d    = state_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    wd_d       = wd_q;
    word_d     = word_q;
    hex_hi_d   = hex_hi_q;
    hex_lo_d   = hex_lo_q;
    blank_d    = blank_q;
    code_err_d = code_err_q;
    dec_hi     = decode(pend_hi_q);
    dec_lo     = decode(pend_lo_q);

    // Comparing the incoming sample with S makes the counter describe S vs P
    // as they stand after this edge, so capture lands SETTLE-1 edges after
    // a new value first enters S.
    if (s_d != s_q) begin
      cnt_d   = 4'd1;
      state_d = ST_SETTLING;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end

    capture = (state_d == ST_SETTLING) && (cnt_d == SETTLE_C);
    if (capture) begin
      state_d = ST_CAPTURED;
      if (s_d[7]) pend_hi_d = s_d[6:0];
      else        pend_lo_d = s_d[6:0];
    end

    // Commit reads the pre-edge pend values; a same-edge capture feeds the next frame.
    commit        = got_hi_q & got_lo_q;
    frame_valid_d = commit;
    got_hi_d      = (got_hi_q & ~commit) | (capture & s_d[7]);
    got_lo_d      = (got_lo_q & ~commit) | (capture & ~s_d[7]);
    if (commit) begin
      word_d     = {pend_hi_q, pend_lo_q};
      hex_hi_d   = dec_hi[3:0];
      hex_lo_d   = dec_lo[3:0];
      blank_d    = {dec_hi[4], dec_lo[4]};
      code_err_d = {dec_hi[5], dec_lo[5]};
    end

    if (s_d[7] != s_q[7])      wd_d = '0;
    else if (wd_q != TIMEOUT_C) wd_d = wd_q + 1'b1;
    scan_lost_d = (wd_d == TIMEOUT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q           <= '0;
      cnt_q         <= '0;
      state_q       <= ST_SETTLING;
      pend_hi_q     <= '0;
      pend_lo_q     <= '0;
      got_hi_q      <= 1'b0;
      got_lo_q      <= 1'b0;
      wd_q          <= '0;
      scan_lost_q   <= 1'b0;
      word_q        <= '0;
      hex_hi_q      <= '0;
      hex_lo_q      <= '0;
      blank_q       <= '0;
      code_err_q    <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      s_q           <= s_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      got_hi_q      <= got_hi_d;
      got_lo_q      <= got_lo_d;
      wd_q          <= wd_d;
      scan_lost_q   <= scan_lost_d;
      word_q        <= word_d;
      hex_hi_q      <= hex_hi_d;
      hex_lo_q      <= hex_lo_d;
      blank_q       <= blank_d;
      code_err_q    <= code_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign both7seg_out = word_q;
  assign hex_hi       = hex_hi_q;
  assign hex_lo       = hex_lo_q;
  assign blank        = blank_q;
  assign code_err     = code_err_q;
  assign frame_valid  = frame_valid_q;
  assign scan_lost    = scan_lost_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: phase settling, glitch rejection,
// decode table, blank/invalid flags, watchdog and mid-frame reset.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segment;
  logic        digit_sel;
  logic [13:0] both7seg_out;
  logic [3:0]  hex_hi, hex_lo;
  logic [1:0]  blank, code_err;
  logic        frame_valid, scan_lost;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int base;

  logic [6:0] tv_hi [6] = '{7'h3F, 7'h6D, 7'h07, 7'h6F, 7'h7C, 7'h5E};
  logic [6:0] tv_lo [6] = '{7'h66, 7'h7D, 7'h7F, 7'h77, 7'h39, 7'h79};
  logic [3:0] ex_hi [6] = '{4'h0, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD};
  logic [3:0] ex_lo [6] = '{4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};

  always #5 clk = ~clk;

  seven_seg_capture #(.SETTLE(4), .TIMEOUT(2048), .TBITS(12)) dut (
    .clk(clk), .rst(rst), .segment(segment), .digit_sel(digit_sel),
    .both7seg_out(both7seg_out), .hex_hi(hex_hi), .hex_lo(hex_lo),
    .blank(blank), .code_err(code_err), .frame_valid(frame_valid),
    .scan_lost(scan_lost)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one bus value for n clock edges, sampling frame_valid on each falling edge.
  task automatic hold(input logic s, input logic [6:0] g, input int n);
    digit_sel = s;
    segment   = g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) fv_cnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 32'(both7seg_out), 32'h0);
    check({tag, "_hex"}, {24'h0, hex_hi, hex_lo}, 32'h0);
    check({tag, "_flags"}, {28'h0, blank, code_err}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    digit_sel = 1'b0;
    segment = 7'h00;
    hold(1'b0, 7'h00, 3);
    rst = 1'b0;
    check_zero("reset");
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_lost", 32'(scan_lost), 32'h0);

    // Basic frame: high 1, low 2
    base = fv_cnt;
    hold(1'b1, 7'h06, 6);
    hold(1'b0, 7'h5B, 6);
    check("basic_fv_count", 32'(fv_cnt - base), 32'd1);
    check("basic_word", 32'(both7seg_out), 32'h035B);
    check("basic_hex", {24'h0, hex_hi, hex_lo}, 32'h12);
    check("basic_flags", {28'h0, blank, code_err}, 32'h0);

    // Glitch on the low phase: 3F for two edges must not be captured
    base = fv_cnt;
    hold(1'b1, 7'h6D, 6);
    hold(1'b0, 7'h3F, 2);
    check("glitch_no_commit", 32'(fv_cnt - base), 32'd0);
    hold(1'b0, 7'h4F, 7);
    check("glitch_fv_count", 32'(fv_cnt - base), 32'd1);
    check("glitch_hex", {24'h0, hex_hi, hex_lo}, 32'h53);
    check("glitch_word", 32'(both7seg_out), 32'h36CF);

    // Blank high digit, invalid low digit
    hold(1'b1, 7'h00, 6);
    hold(1'b0, 7'h2A, 6);
    check("bad_blank", 32'(blank), 32'h2);
    check("bad_code_err", 32'(code_err), 32'h1);
    check("bad_hex", {24'h0, hex_hi, hex_lo}, 32'h0);
    check("bad_word", 32'(both7seg_out), 32'h002A);

    // Decode table sweep
    for (int k = 0; k < 6; k++) begin
      base = fv_cnt;
      hold(1'b1, tv_hi[k], 6);
      hold(1'b0, tv_lo[k], 6);
      check($sformatf("table%0d_fv", k), 32'(fv_cnt - base), 32'd1);
      check($sformatf("table%0d_hex", k), {24'h0, hex_hi, hex_lo}, {24'h0, ex_hi[k], ex_lo[k]});
      check($sformatf("table%0d_flags", k), {28'h0, blank, code_err}, 32'h0);
    end

    // Watchdog: sel stuck high; seed a known frame first
    hold(1'b1, 7'h00, 6);
    hold(1'b0, 7'h2A, 6);
    hold(1'b1, 7'h06, 2040);
    check("wd_early", 32'(scan_lost), 32'h0);
    hold(1'b1, 7'h06, 10);
    check("wd_lost", 32'(scan_lost), 32'h1);
    hold(1'b1, 7'h06, 50);
    check("wd_lost_held", 32'(scan_lost), 32'h1);
    check("wd_word_held", 32'(both7seg_out), 32'h002A);
    hold(1'b0, 7'h5B, 2);
    check("wd_recover", 32'(scan_lost), 32'h0);
    check("wd_word_kept", 32'(both7seg_out), 32'h002A);

    // Reset after only the high digit has been captured
    hold(1'b1, 7'h06, 6);
    rst = 1'b1;
    hold(1'b1, 7'h06, 2);
    rst = 1'b0;
    check_zero("midrst");
    base = fv_cnt;
    hold(1'b0, 7'h5B, 10);
    check("midrst_no_fv", 32'(fv_cnt - base), 32'd0);
    check_zero("midrst_lo_only");
    hold(1'b1, 7'h06, 6);
    check("midrst_fv", 32'(fv_cnt - base), 32'd1);
    check("midrst_word", 32'(both7seg_out), 32'h035B);

    // Continuous alternation every 8 cycles: F on high, A on low
    rst = 1'b1;
    hold(1'b0, 7'h00, 2);
    rst = 1'b0;
    base = fv_cnt;
    for (int k = 0; k < 4; k++) begin
      hold(1'b1, 7'h71, 8);
      hold(1'b0, 7'h77, 8);
    end
    check("alt_fv_count", 32'(fv_cnt - base), 32'd4);
    check("alt_hex", {24'h0, hex_hi, hex_lo}, 32'hFA);
    check("alt_word", 32'(both7seg_out), 32'h38F7);
    check("alt_lost", 32'(scan_lost), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
Receive-side companion to the two-digit multiplexed seven-segment driver. It monitors a shared segment bus and its digit-select line, and waits for each phase to settle before capturing it. It rebuilds the 14-bit two-digit segment word, decodes each digit to hex, and flags invalid or blank patterns. It is used in display-loopback self-test and to scrape front-panel displays.

Parameters:
SETTLE, 4, consecutive identical samples required before a phase is captured (2..15)
TIMEOUT, 2048, cycles without a digit_sel toggle before scan_lost asserts
TBITS, 12, width of the timeout counter; must hold TIMEOUT

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
segment  input  7  multiplexed segment bus, active-high; bit0=a, bit1=b, ... bit6=g
digit_sel  input  1  1 = high digit on bus, 0 = low digit
both7seg_out  output  14  [13:7] high-digit segments, [6:0] low-digit segments
hex_hi  output  4  decoded high digit
hex_lo  output  4  decoded low digit
blank  output  2  [1] high digit blank, [0] low digit blank (pattern 7'h00)
code_err  output  2  [1] high, [0] low; non-blank pattern not in the decode table
frame_valid  output  1  one-cycle pulse when all outputs update
scan_lost  output  1  level; digit_sel has not toggled for TIMEOUT cycles

Behaviour:
- Reset (sync, highest priority, any cycle): all outputs 0, all internal registers 0, pending flags cleared. Reset mid-frame discards any half-captured frame.
- Input stage: {digit_sel, segment} registered every cycle into the sample register S. Prev register P holds the previous S.
- Stability counter:
  - If S != P, counter := 1 and the captured-run flag is cleared.
  - Otherwise counter increments, saturating at SETTLE.
- Capture:
  - On the cycle the counter becomes SETTLE with the captured-run flag clear, store S.segment into pend_hi (S.sel=1) or pend_lo (S.sel=0).
  - Set got_hi or got_lo, and set the captured-run flag.
  - Exactly one capture per stable run. If the bus changes within a phase and restabilizes, a new capture overwrites that half.
- Latency: a value first held on the inputs before edge E0 is in S after E0. Its capture occurs at edge E0+SETTLE-1.
- Frame commit:
  - When got_hi and got_lo are both set, the next edge loads both7seg_out = {pend_hi, pend_lo} and updates hex_hi, hex_lo, blank and code_err.
  - frame_valid = 1 for exactly that cycle; got_hi and got_lo are cleared.
  - Capture order is irrelevant.
  - If a capture and a commit fall on the same edge, the commit uses the previous pend values. The new capture sets its got flag for the next frame.
- Decode table (hex value: pattern):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - 7'h00 gives blank=1, hex=0, code_err=0.
  - Any other pattern gives code_err=1, hex=0, blank=0.
  - Decode is combinational from the pend values and registered at commit. Outputs hold between commits.
- Scan watchdog:
  - Counter cleared on any S.sel != P.sel; otherwise increments, saturating at TIMEOUT.
  - scan_lost = (counter == TIMEOUT), registered.
  - scan_lost deasserts on the edge after the next toggle. Outputs are not cleared while scan_lost is asserted.
- State machine per phase: SETTLING (counter < SETTLE), CAPTURED (flag set, awaiting change). Any S != P returns to SETTLING.

Test Plan:
- Reset, then hold sel=1, seg=7'h06 for 6 cycles, then sel=0, seg=7'h5B for 6 cycles -> frame_valid single pulse; both7seg_out=14'h035B, hex_hi=1, hex_lo=2, blank=0, code_err=0.
- Glitch: sel=0, seg=7'h3F for 2 cycles, then 7'h4F for 5 cycles, with the high digit 7'h6D -> hex_lo=3 (7'h3F never captured), hex_hi=5.
- High digit 7'h00, low digit 7'h2A -> blank=2'b10, code_err=2'b01, hex_hi=0, hex_lo=0.
- Hold sel=1 constant for 2100 cycles -> scan_lost=1 by cycle 2048+2. Toggle sel -> scan_lost=0 after one edge; both7seg_out unchanged.
- Assert rst after only the high digit is captured, then supply only the low digit -> no frame_valid until a high digit is also captured; all outputs stay 0.
- Continuous alternation every 8 cycles between 7'h71 (hi) and 7'h77 (lo) -> frame_valid exactly once per two phases; hex_hi=F, hex_lo=A stable.
